// File: rtl/output_sequencer.sv
// Buffers control-unit words in a small FIFO and issues one shift_register load per frame.
// Optional OUTPUT_SEQ_PARITY_EN adds a one-cycle PARITY state and the parity_out/parity_valid ports.
module output_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          overflow_clr,
  output logic                          ser_load,
  output logic [DATA_WIDTH-1:0]         ser_data,
  output logic                          frame_valid,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
`ifdef OUTPUT_SEQ_PARITY_EN
  ,
  output logic                          parity_out,
  output logic                          parity_valid
`endif
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CMAX = (DATA_WIDTH > GAP_CYCLES) ? DATA_WIDTH : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] LAST_GAP = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
`ifdef OUTPUT_SEQ_PARITY_EN
    PARITY,
`endif
    GAP
  } state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  state_t                state;
  logic                  pop;
  logic                  push_ok;
  logic                  drop;
  logic [AW:0]           count_nxt;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push while IDLE pops.
  always_comb begin
    pop       = (state == IDLE) && (fifo_count != '0);
    push_ok   = in_valid && ((fifo_count != FULL_CNT) || pop);
    drop      = in_valid && !push_ok;
    count_nxt = fifo_count;
    if (push_ok && !pop)
      count_nxt = fifo_count + CNT_ONE;
    else if (pop && !push_ok)
      count_nxt = fifo_count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_nxt;
      if (drop)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;
    end
  end

  // frame_valid trails the SHIFT state by one cycle so it covers the cycles after the load pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      ser_load     <= 1'b0;
      ser_data     <= '0;
      frame_valid  <= 1'b0;
      busy         <= 1'b0;
`ifdef OUTPUT_SEQ_PARITY_EN
      parity_out   <= 1'b0;
      parity_valid <= 1'b0;
`endif
    end else begin
      ser_load    <= 1'b0;
      frame_valid <= (state == SHIFT);
      busy        <= 1'b1;
`ifdef OUTPUT_SEQ_PARITY_EN
      parity_out   <= 1'b0;
      parity_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pop) begin
            ser_load <= 1'b1;
            ser_data <= mem[rd_ptr];
            cnt      <= '0;
            state    <= SHIFT;
          end else begin
            busy <= push_ok;
          end
        end
        SHIFT: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            cnt <= '0;
`ifdef OUTPUT_SEQ_PARITY_EN
            state <= PARITY;
`else
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
              busy  <= (count_nxt != '0);
            end else begin
              state <= GAP;
            end
`endif
          end
        end
`ifdef OUTPUT_SEQ_PARITY_EN
        PARITY: begin
          parity_valid <= 1'b1;
          parity_out   <= ^ser_data;
          cnt          <= '0;
          if (GAP_CYCLES == 0) begin
            state <= IDLE;
            busy  <= (count_nxt != '0);
          end else begin
            state <= GAP;
          end
        end
`endif
        GAP: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST_GAP) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= (count_nxt != '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_sequencer.sv
// Directed bench for output_sequencer (DATA_WIDTH=8, FIFO_DEPTH=4, GAP_CYCLES=1), parity checks under OUTPUT_SEQ_PARITY_EN.
module tb_output_sequencer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int GAP   = 1;
`ifdef OUTPUT_SEQ_PARITY_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif
  localparam int SPACING = DW + GAP + 1 + PX;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          overflow_clr = 1'b0;
  logic          ser_load;
  logic [DW-1:0] ser_data;
  logic          frame_valid;
  logic          busy;
  logic [2:0]    fifo_count;
  logic          overflow;
`ifdef OUTPUT_SEQ_PARITY_EN
  logic          parity_out;
  logic          parity_valid;
`endif

  output_sequencer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .overflow_clr(overflow_clr), .ser_load(ser_load), .ser_data(ser_data),
    .frame_valid(frame_valid), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
`ifdef OUTPUT_SEQ_PARITY_EN
    , .parity_out(parity_out), .parity_valid(parity_valid)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          clr;
    logic [14:0]   exp;
  } vec_t;

  vec_t tv[$];

  function automatic logic [14:0] e(input logic sl, input logic [7:0] sd, input logic fv,
                                    input logic b, input logic [2:0] fc, input logic ov);
    return {sl, sd, fv, b, fc, ov};
  endfunction

  function automatic logic [14:0] obs();
    return {ser_load, ser_data, frame_valid, busy, fifo_count, overflow};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_table(input string tag);
    foreach (tv[i]) begin
      in_valid     = tv[i].iv;
      in_data      = tv[i].id;
      overflow_clr = tv[i].clr;
      step();
      chk($sformatf("%s[%0d] {load,data,fv,busy,cnt,ovf}", tag, i), 32'(obs()), 32'(tv[i].exp));
    end
    in_valid     = 1'b0;
    overflow_clr = 1'b0;
    tv.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk("wait_idle busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int loads;
    int t_load[$];
    logic [DW-1:0] d_load[$];
    int peak;

    // reset held low for three cycles
    repeat (3) step();
    chk("in_reset outputs", 32'(obs()), 32'd0);
    reset = 1'b1;
    step();
    chk("after_reset outputs", 32'(obs()), 32'd0);
`ifdef OUTPUT_SEQ_PARITY_EN
    chk("after_reset parity", 32'({parity_out, parity_valid}), 32'd0);
`endif

    // single word: push, load, 8 frame bits, gap, idle
    tv.push_back('{1'b1, 8'hA5, 1'b0, e(0, 8'h00, 0, 1, 1, 0)});
    tv.push_back('{1'b0, 8'h00, 1'b0, e(1, 8'hA5, 0, 1, 0, 0)});
    for (int k = 0; k < DW; k++)
      tv.push_back('{1'b0, 8'h00, 1'b0, e(0, 8'hA5, 1, 1, 0, 0)});
    tv.push_back('{1'b0, 8'h00, 1'b0, e(0, 8'hA5, 0, (PX == 1), 0, 0)});
    tv.push_back('{1'b0, 8'h00, 1'b0, e(0, 8'hA5, 0, 0, 0, 0)});
    run_table("single");
    wait_idle(20);

    // overflow: six back-to-back pushes, then clear; set beats clear on a same-cycle drop
    tv.push_back('{1'b1, 8'h10, 1'b0, e(0, 8'hA5, 0, 1, 1, 0)});
    tv.push_back('{1'b1, 8'h11, 1'b0, e(1, 8'h10, 0, 1, 1, 0)});
    tv.push_back('{1'b1, 8'h12, 1'b0, e(0, 8'h10, 1, 1, 2, 0)});
    tv.push_back('{1'b1, 8'h13, 1'b0, e(0, 8'h10, 1, 1, 3, 0)});
    tv.push_back('{1'b1, 8'h14, 1'b0, e(0, 8'h10, 1, 1, 4, 0)});
    tv.push_back('{1'b1, 8'h15, 1'b0, e(0, 8'h10, 1, 1, 4, 1)});
    tv.push_back('{1'b0, 8'h00, 1'b1, e(0, 8'h10, 1, 1, 4, 0)});
    tv.push_back('{1'b1, 8'h16, 1'b1, e(0, 8'h10, 1, 1, 4, 1)});
    tv.push_back('{1'b0, 8'h00, 1'b1, e(0, 8'h10, 1, 1, 4, 0)});
    run_table("overflow");
    loads = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (ser_load) begin
        chk($sformatf("overflow load %0d data", loads), 32'(ser_data), 32'(8'h11 + loads));
        loads++;
      end
    end
    chk("overflow remaining loads", 32'(loads), 32'd4);
    wait_idle(20);

    // burst of three: in-order loads at fixed spacing, occupancy peaks at 2
    peak = 0;
    in_valid = 1'b1;
    in_data  = 8'h01;
    for (int k = 0; k < 40; k++) begin
      step();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (ser_load) begin
        t_load.push_back(k);
        d_load.push_back(ser_data);
      end
      in_valid = (k < 2);
      in_data  = 8'(k + 2);
    end
    in_valid = 1'b0;
    chk("burst load count", 32'(t_load.size()), 32'd3);
    if (t_load.size() == 3) begin
      for (int k = 0; k < 3; k++)
        chk($sformatf("burst load %0d data", k), 32'(d_load[k]), 32'(k + 1));
      chk("burst first load latency", 32'(t_load[0]), 32'd1);
      chk("burst spacing 1-2", 32'(t_load[1] - t_load[0]), 32'(SPACING));
      chk("burst spacing 2-3", 32'(t_load[2] - t_load[1]), 32'(SPACING));
    end
    chk("burst fifo_count peak", 32'(peak), 32'd2);
    chk("burst busy at end", 32'(busy), 32'd0);

    // reset at SHIFT count 3 with two words still queued
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_data = 8'h5B;
    step();
    chk("midreset load seen", 32'(ser_load), 32'd1);
    in_data = 8'h5C;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("midreset pre {fv,cnt}", 32'({frame_valid, fifo_count}), 32'({1'b1, 3'd2}));
    reset = 1'b0;
    #1;
    chk("midreset outputs during reset", 32'(obs()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    loads = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (ser_load) loads++;
    end
    chk("midreset loads after release", 32'(loads), 32'd0);
    chk("midreset idle {busy,cnt}", 32'({busy, fifo_count}), 32'd0);

`ifdef OUTPUT_SEQ_PARITY_EN
    for (int w = 0; w < 2; w++) begin
      int since;
      logic seen;
      in_valid = 1'b1;
      in_data  = (w == 0) ? 8'h07 : 8'h03;
      step();
      in_valid = 1'b0;
      since = -1;
      seen  = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        step();
        if (ser_load) since = 0;
        else if (since >= 0) since++;
        if (parity_valid) begin
          seen = 1'b1;
          chk($sformatf("parity %0d offset", w), 32'(since), 32'd9);
          chk($sformatf("parity %0d value", w), 32'(parity_out), (w == 0) ? 32'd1 : 32'd0);
          step();
          chk($sformatf("parity %0d pulse width", w), 32'(parity_valid), 32'd0);
        end
      end
      chk($sformatf("parity %0d seen", w), 32'(seen), 32'd1);
      wait_idle(20);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
